// File: rtl/encoder_pkg.sv
// Shared mode encodings and bit-vector helpers for the priority encoder.
// Helpers take a 64-bit vector so any request width up to 64 can be zero-extended into them.
package encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + {6'd0, v[i]};
    end
    return cnt;
  endfunction

  // Valid only for a one-hot (or zero) input; OR-ing indices avoids a priority chain.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) begin
        idx = idx | 6'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_search.sv
// Combinational grant search: highest-index-wins in fixed mode,
// first set bit at or after start (wrapping) in round-robin mode.
module prio_search
  import encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam logic [W:0] N_VAL = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_dbl_shift;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_low;
  logic [W-1:0]   w_off;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_rr_idx;
  logic [W-1:0]   w_fix_idx;

  // Rotate so that bit 'start' lands at position 0, isolate the lowest set bit,
  // then add the offset back modulo N (N need not be a power of two).
  always_comb begin
    w_dbl       = {req, req};
    w_dbl_shift = w_dbl >> start;
    w_rot       = w_dbl_shift[N-1:0];
    w_low       = w_rot & (~w_rot + N'(1));
    w_off       = W'(onehot_to_idx(64'(w_low)));
    w_sum       = {1'b0, start} + {1'b0, w_off};
    if (w_sum >= N_VAL) begin
      w_sum = w_sum - N_VAL;
    end else begin
      w_sum = w_sum;
    end
    w_rr_idx = w_sum[W-1:0];
  end

  // Fixed priority: last set bit in ascending scan is the highest index.
  always_comb begin
    w_fix_idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        w_fix_idx = W'(i);
      end else begin
        w_fix_idx = w_fix_idx;
      end
    end
  end

  // Select result by mode.
  always_comb begin
    found = |req;
    if (mode == MODE_RR) begin
      idx = w_rr_idx;
    end else begin
      idx = w_fix_idx;
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed/round-robin arbitration
// and a valid/ready output handshake.
module prio_encoder_rr
  import encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic         w_hs;
  logic         w_load;
  logic [W-1:0] w_ptr_nxt;
  logic         w_found;
  logic [W-1:0] w_idx;

  assign w_hs   = r_valid && out_ready;
  assign w_load = !r_valid || out_ready;

  // The pointer advances past an accepted grant; a load in the same cycle searches from it.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_hs && (mode == MODE_RR)) begin
      if (r_idx == W'(N-1)) begin
        w_ptr_nxt = {W{1'b0}};
      end else begin
        w_ptr_nxt = r_idx + W'(1);
      end
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  prio_search #(.N(N)) u_search (
    .req   (req),
    .start (w_ptr_nxt),
    .mode  (mode),
    .found (w_found),
    .idx   (w_idx)
  );

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= {W{1'b0}};
      r_onehot <= {N{1'b0}};
      r_multi  <= 1'b0;
      r_ptr    <= {W{1'b0}};
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_load) begin
        if (w_found) begin
          r_valid  <= 1'b1;
          r_idx    <= w_idx;
          r_onehot <= N'(1) << w_idx;
          r_multi  <= (popcount(64'(req)) > 7'd1);
        end else begin
          r_valid  <= 1'b0;
          r_idx    <= {W{1'b0}};
          r_onehot <= {N{1'b0}};
          r_multi  <= 1'b0;
        end
      end else begin
        r_valid  <= r_valid;
        r_idx    <= r_idx;
        r_onehot <= r_onehot;
        r_multi  <= r_multi;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_multi  = r_multi;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: an N=8 and an N=5 instance against a behavioural model.
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       out_ready;
  logic [7:0] req8;
  logic [4:0] req5;

  logic       v8, m8_o, v5, m5_o;
  logic [2:0] idx8, idx5;
  logic [7:0] oh8;
  logic [4:0] oh5;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          valid;
    int          idx;
    logic [63:0] onehot;
    bit          multi;
    int          ptr;
  } mdl_t;

  mdl_t m8, m5;
  mdl_t q8[$];
  mdl_t q5[$];

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .mode(mode), .out_ready(out_ready),
    .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .out_multi(m8_o)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .mode(mode), .out_ready(out_ready),
    .out_valid(v5), .out_idx(idx5), .out_onehot(oh5), .out_multi(m5_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t model_next(mdl_t m, int n, logic [63:0] rq, bit md, bit rdy, bit rs);
    mdl_t r;
    bit   hit;
    r = m;
    if (rs) begin
      r.valid = 1'b0; r.idx = 0; r.onehot = 64'd0; r.multi = 1'b0; r.ptr = 0;
      return r;
    end
    if (m.valid && rdy && md) r.ptr = (m.idx + 1) % n;
    if (!m.valid || rdy) begin
      if (rq == 64'd0) begin
        r.valid = 1'b0; r.idx = 0; r.onehot = 64'd0; r.multi = 1'b0;
      end else begin
        r.valid = 1'b1;
        r.multi = ($countones(rq) > 1);
        if (!md) begin
          for (int i = 0; i < n; i++) if (rq[i]) r.idx = i;
        end else begin
          hit = 1'b0;
          for (int k = 0; k < n; k++) begin
            if (!hit && rq[(r.ptr + k) % n]) begin
              r.idx = (r.ptr + k) % n;
              hit = 1'b1;
            end
          end
        end
        r.onehot = 64'd1 << r.idx;
      end
    end
    return r;
  endfunction

  // Push expectations for the current inputs, clock once, then pop and compare.
  task automatic step(input string tag);
    mdl_t e;
    m8 = model_next(m8, 8, {56'd0, req8}, mode, out_ready, rst);
    m5 = model_next(m5, 5, {59'd0, req5}, mode, out_ready, rst);
    q8.push_back(m8);
    q5.push_back(m5);
    @(posedge clk);
    #1;
    e = q8.pop_front();
    check_eq({tag, "/v8"},   64'(v8),   64'(e.valid));
    check_eq({tag, "/idx8"}, 64'(idx8), 64'(e.idx));
    check_eq({tag, "/oh8"},  64'(oh8),  e.onehot);
    check_eq({tag, "/mu8"},  64'(m8_o), 64'(e.multi));
    e = q5.pop_front();
    check_eq({tag, "/v5"},   64'(v5),   64'(e.valid));
    check_eq({tag, "/idx5"}, 64'(idx5), 64'(e.idx));
    check_eq({tag, "/oh5"},  64'(oh5),  e.onehot);
    check_eq({tag, "/mu5"},  64'(m5_o), 64'(e.multi));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("rst");
    step("rst");
    rst = 1'b0;
  endtask

  int exp5[4] = '{4, 0, 4, 0};

  initial begin
    m8 = '{1'b0, 0, 64'd0, 1'b0, 0};
    m5 = '{1'b0, 0, 64'd0, 1'b0, 0};
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1; req8 = 8'hFF; req5 = 5'd0;

    // 1: reset dominates a full request vector
    step("t1a");
    check_eq("t1a_valid", 64'(v8), 64'd0);
    step("t1b");
    check_eq("t1b_valid", 64'(v8), 64'd0);
    check_eq("t1b_idx", 64'(idx8), 64'd0);
    check_eq("t1b_oh", 64'(oh8), 64'd0);

    // 2: fixed priority
    rst = 1'b0; mode = 1'b0; req8 = 8'b0001_0100;
    step("t2a");
    check_eq("t2_idx", 64'(idx8), 64'd4);
    check_eq("t2_oh", 64'(oh8), 64'h10);
    check_eq("t2_multi", 64'(m8_o), 64'd1);
    req8 = 8'b1010_0000;
    step("t2b");
    check_eq("t2_high", 64'(idx8), 64'd7);
    req8 = 8'd0;
    step("t2c");
    check_eq("t2_empty", 64'(v8), 64'd0);

    // 3: round-robin sweep
    do_reset();
    mode = 1'b1; req8 = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step("t3");
      check_eq("t3_seq", 64'(idx8), 64'(i % 8));
    end

    // 4: stall holds the grant and ignores request changes
    do_reset();
    mode = 1'b1; out_ready = 1'b1; req8 = 8'b1000_0001;
    step("t4a");
    check_eq("t4_first", 64'(idx8), 64'd0);
    out_ready = 1'b0; req8 = 8'b0000_0010;
    for (int i = 0; i < 3; i++) begin
      step("t4s");
      check_eq("t4_hold", 64'(idx8), 64'd0);
      check_eq("t4_hold_v", 64'(v8), 64'd1);
    end
    req8 = 8'b1000_0001; out_ready = 1'b1;
    step("t4b");
    check_eq("t4_after", 64'(idx8), 64'd7);
    step("t4c");
    check_eq("t4_wrap", 64'(idx8), 64'd0);

    // 5: N=5 wraps 4 -> 0
    do_reset();
    req8 = 8'd0; mode = 1'b1; out_ready = 1'b1; req5 = 5'b10001;
    step("t5a");
    check_eq("t5_first", 64'(idx5), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step("t5");
      check_eq("t5_alt", 64'(idx5), 64'(exp5[i]));
    end
    req5 = 5'd0;

    // 6: mid-operation reset clears the pointer
    do_reset();
    mode = 1'b1; req8 = 8'hFF;
    for (int i = 0; i < 4; i++) step("t6w");
    check_eq("t6_pre", 64'(idx8), 64'd3);
    rst = 1'b1;
    step("t6r");
    check_eq("t6_clr_v", 64'(v8), 64'd0);
    check_eq("t6_clr_oh", 64'(oh8), 64'd0);
    rst = 1'b0;
    step("t6n");
    check_eq("t6_restart", 64'(idx8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
